// File: rtl/wb_regfile_if.sv
// Write-back stage bus: MEM/WB pipeline register fields in, ID-stage read ports and
// forwarding/retire information out.
interface wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [DW-1:0] ALUResult_WB;
    logic [DW-1:0] ReadDataFromMem_WB;
    logic [DW-1:0] NextInstruct_WB;
    logic [31:0]   Instruction_WB;
    logic          MemtoReg_WB;
    logic          RegWrite_WB;
    logic          RegWriteSel_WB;
    logic          Zero_WB;
    logic [1:0]    RegDst_WB;
    logic [AW-1:0] ReadReg1;
    logic [AW-1:0] ReadReg2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          WBWriteEn;
    logic [AW-1:0] WBWriteReg;
    logic [DW-1:0] WBWriteData;
    logic [31:0]   RetiredCount;

    modport master (
        output ALUResult_WB, ReadDataFromMem_WB, NextInstruct_WB, Instruction_WB,
               MemtoReg_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RegDst_WB,
               ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, WBWriteEn, WBWriteReg, WBWriteData, RetiredCount
    );

    modport slave (
        input  ALUResult_WB, ReadDataFromMem_WB, NextInstruct_WB, Instruction_WB,
               MemtoReg_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RegDst_WB,
               ReadReg1, ReadReg2,
        output ReadData1, ReadData2, WBWriteEn, WBWriteReg, WBWriteData, RetiredCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects destination/data, commits into the architectural register
// file, serves two bypassed read ports and counts retired (non-bubble) instructions.
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    wb_regfile_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [DW-1:0] regs [NREGS];
    logic [31:0]   retiredCnt;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          writeEn;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    always_comb begin
        writeReg = bus.Instruction_WB[15:11];
        case (bus.RegDst_WB)
            2'b00:   writeReg = bus.Instruction_WB[20:16];
            2'b10:   writeReg = AW'(NREGS - 1);
            default: writeReg = bus.Instruction_WB[15:11];
        endcase
    end

    // Link forms always write the return PC, even if MemtoReg happens to be set.
    always_comb begin
        writeData = bus.ALUResult_WB;
        if (bus.RegDst_WB[1])
            writeData = bus.NextInstruct_WB;
        else if (bus.MemtoReg_WB)
            writeData = bus.ReadDataFromMem_WB;
    end

    assign writeEn = bus.RegWrite_WB & (~bus.RegWriteSel_WB | bus.Zero_WB) & (writeReg != '0);

    // Bypass the in-flight write so ID sees it in the same cycle.
    always_comb begin
        readData1 = regs[bus.ReadReg1];
        if (bus.ReadReg1 == '0)
            readData1 = '0;
        else if (writeEn && bus.ReadReg1 == writeReg)
            readData1 = writeData;
    end

    always_comb begin
        readData2 = regs[bus.ReadReg2];
        if (bus.ReadReg2 == '0)
            readData2 = '0;
        else if (writeEn && bus.ReadReg2 == writeReg)
            readData2 = writeData;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            retiredCnt <= '0;
        end else begin
            if (writeEn)
                regs[writeReg] <= writeData;
            if (bus.Instruction_WB != 32'h0)
                retiredCnt <= retiredCnt + 32'd1;
        end
    end

    assign bus.ReadData1    = readData1;
    assign bus.ReadData2    = readData2;
    assign bus.WBWriteEn    = writeEn;
    assign bus.WBWriteReg   = writeReg;
    assign bus.WBWriteData  = writeData;
    assign bus.RetiredCount = retiredCnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, destination/data select, bypass, conditional
// write, $0 protection, back-to-back commits and retire counter wrap.
module tb_wb_regfile;
    logic Clk;
    logic Reset;
    int   passCnt;
    int   totalCnt;

    wb_regfile_if #(.DW(32), .AW(5)) bus ();

    wb_regfile #(.NREGS(32), .DW(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mkInstr(input logic [4:0] rt, input logic [4:0] rd);
        return {6'h01, 5'd0, rt, rd, 11'd0};
    endfunction

    task automatic setWB(input logic [1:0] dst, input logic mtr, input logic rw,
                         input logic rws, input logic z, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] nxt);
        bus.RegDst_WB          = dst;
        bus.MemtoReg_WB        = mtr;
        bus.RegWrite_WB        = rw;
        bus.RegWriteSel_WB     = rws;
        bus.Zero_WB            = z;
        bus.Instruction_WB     = mkInstr(rt, rd);
        bus.ALUResult_WB       = alu;
        bus.ReadDataFromMem_WB = mem;
        bus.NextInstruct_WB    = nxt;
    endtask

    task automatic idle();
        bus.RegDst_WB          = 2'b00;
        bus.MemtoReg_WB        = 1'b0;
        bus.RegWrite_WB        = 1'b0;
        bus.RegWriteSel_WB     = 1'b0;
        bus.Zero_WB            = 1'b0;
        bus.Instruction_WB     = 32'h0;
        bus.ALUResult_WB       = 32'h0;
        bus.ReadDataFromMem_WB = 32'h0;
        bus.NextInstruct_WB    = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd31;
        Reset = 1'b0;
        #12;
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0)
            $display("FAIL reset_reads got %h/%h exp 0/0", bus.ReadData1, bus.ReadData2);
        else passCnt++;
        totalCnt++;
        if (bus.RetiredCount !== 32'h0)
            $display("FAIL reset_count got %h exp 0", bus.RetiredCount);
        else passCnt++;

        setWB(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 32'h1234, 32'h0, 32'h0);
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h1234)
            $display("FAIL reset_prewrite got %h exp 00001234", bus.ReadData1);
        else passCnt++;
        Reset = 1'b0;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0)
            $display("FAIL reset_midcycle_rd got %h exp 0", bus.ReadData1);
        else passCnt++;
        totalCnt++;
        if (bus.RetiredCount !== 32'h0)
            $display("FAIL reset_midcycle_count got %h exp 0", bus.RetiredCount);
        else passCnt++;

        // Pending write across an edge while reset is held must be dropped.
        setWB(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 32'h55, 32'h0, 32'h0);
        @(negedge Clk);
        idle();
        #1;
        Reset = 1'b1;
        bus.ReadReg1 = 5'd6;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0)
            $display("FAIL reset_drop_write got %h exp 0", bus.ReadData1);
        else passCnt++;
    endtask

    task automatic test_rtype();
        @(negedge Clk);
        setWB(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd8, 32'hDEADBEEF, 32'h0, 32'h0);
        bus.ReadReg1 = 5'd8;
        bus.ReadReg2 = 5'd8;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'hDEADBEEF || bus.ReadData2 !== 32'hDEADBEEF)
            $display("FAIL rtype_bypass got %h/%h exp deadbeef", bus.ReadData1, bus.ReadData2);
        else passCnt++;
        totalCnt++;
        if (bus.WBWriteEn !== 1'b1 || bus.WBWriteReg !== 5'd8)
            $display("FAIL rtype_dest got en=%b reg=%0d exp en=1 reg=8", bus.WBWriteEn, bus.WBWriteReg);
        else passCnt++;
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'hDEADBEEF)
            $display("FAIL rtype_commit got %h exp deadbeef", bus.ReadData1);
        else passCnt++;
    endtask

    task automatic test_load_link();
        @(negedge Clk);
        setWB(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 32'h1, 32'hA5A5A5A5, 32'h0);
        #1;
        totalCnt++;
        if (bus.WBWriteReg !== 5'd9 || bus.WBWriteData !== 32'hA5A5A5A5)
            $display("FAIL load_select got reg=%0d data=%h exp reg=9 data=a5a5a5a5", bus.WBWriteReg, bus.WBWriteData);
        else passCnt++;
        @(negedge Clk);
        setWB(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd7, 32'h2, 32'h3, 32'h00400010);
        bus.ReadReg1 = 5'd9;
        bus.ReadReg2 = 5'd3;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'hA5A5A5A5 || bus.ReadData2 !== 32'h0)
            $display("FAIL load_commit got r9=%h r3=%h exp a5a5a5a5/0", bus.ReadData1, bus.ReadData2);
        else passCnt++;
        totalCnt++;
        if (bus.WBWriteReg !== 5'd31 || bus.WBWriteData !== 32'h00400010)
            $display("FAIL jal_select got reg=%0d data=%h exp reg=31 data=00400010", bus.WBWriteReg, bus.WBWriteData);
        else passCnt++;
        @(negedge Clk);
        setWB(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd12, 32'h2, 32'h3, 32'h00400020);
        bus.ReadReg1 = 5'd31;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h00400010)
            $display("FAIL jal_commit got %h exp 00400010", bus.ReadData1);
        else passCnt++;
        totalCnt++;
        if (bus.WBWriteReg !== 5'd12 || bus.WBWriteData !== 32'h00400020)
            $display("FAIL jalr_select got reg=%0d data=%h exp reg=12 data=00400020", bus.WBWriteReg, bus.WBWriteData);
        else passCnt++;
        @(negedge Clk);
        idle();
        bus.ReadReg1 = 5'd12;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h00400020)
            $display("FAIL jalr_commit got %h exp 00400020", bus.ReadData1);
        else passCnt++;
    endtask

    task automatic test_cond_write();
        @(negedge Clk);
        setWB(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd10, 32'h77, 32'h0, 32'h0);
        bus.ReadReg1 = 5'd10;
        #1;
        totalCnt++;
        if (bus.WBWriteEn !== 1'b0)
            $display("FAIL cond_z0_en got %b exp 0", bus.WBWriteEn);
        else passCnt++;
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0)
            $display("FAIL cond_z0_reg got %h exp 0", bus.ReadData1);
        else passCnt++;
        setWB(2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd10, 32'h77, 32'h0, 32'h0);
        #1;
        totalCnt++;
        if (bus.WBWriteEn !== 1'b1)
            $display("FAIL cond_z1_en got %b exp 1", bus.WBWriteEn);
        else passCnt++;
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h77)
            $display("FAIL cond_z1_reg got %h exp 00000077", bus.ReadData1);
        else passCnt++;
    endtask

    task automatic test_reg_zero();
        @(negedge Clk);
        setWB(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
        bus.ReadReg1 = 5'd0;
        bus.ReadReg2 = 5'd0;
        #1;
        totalCnt++;
        if (bus.WBWriteEn !== 1'b0)
            $display("FAIL zero_en got %b exp 0", bus.WBWriteEn);
        else passCnt++;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0)
            $display("FAIL zero_bypass got %h/%h exp 0/0", bus.ReadData1, bus.ReadData2);
        else passCnt++;
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0)
            $display("FAIL zero_commit got %h/%h exp 0/0", bus.ReadData1, bus.ReadData2);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        setWB(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 32'h11, 32'h0, 32'h0);
        @(negedge Clk);
        setWB(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0, 32'h22, 32'h0, 32'h0);
        bus.ReadReg1 = 5'd1;
        bus.ReadReg2 = 5'd2;
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h11 || bus.ReadData2 !== 32'h22)
            $display("FAIL b2b_mixed got %h/%h exp 11/22", bus.ReadData1, bus.ReadData2);
        else passCnt++;
        @(negedge Clk);
        idle();
        #1;
        totalCnt++;
        if (bus.ReadData1 !== 32'h11 || bus.ReadData2 !== 32'h22)
            $display("FAIL b2b_commit got %h/%h exp 11/22", bus.ReadData1, bus.ReadData2);
        else passCnt++;
    endtask

    task automatic test_retire();
        logic [7:0] pattern;
        pattern = 8'b1011_0101;
        @(negedge Clk);
        idle();
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            bus.Instruction_WB = pattern[i] ? (32'h0000_1000 + 32'(i)) : 32'h0;
        end
        @(negedge Clk);
        bus.Instruction_WB = 32'h0;
        #1;
        totalCnt++;
        if (bus.RetiredCount !== 32'd5)
            $display("FAIL retire_count got %0d exp 5", bus.RetiredCount);
        else passCnt++;
        force dut.retiredCnt = 32'hFFFFFFFF;
        #1;
        release dut.retiredCnt;
        #1;
        totalCnt++;
        if (bus.RetiredCount !== 32'hFFFFFFFF)
            $display("FAIL retire_preset got %h exp ffffffff", bus.RetiredCount);
        else passCnt++;
        bus.Instruction_WB = 32'h2000_0000;
        @(negedge Clk);
        bus.Instruction_WB = 32'h0;
        #1;
        totalCnt++;
        if (bus.RetiredCount !== 32'h0)
            $display("FAIL retire_wrap got %h exp 0", bus.RetiredCount);
        else passCnt++;
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        Reset    = 1'b0;
        idle();
        bus.ReadReg1 = 5'd0;
        bus.ReadReg2 = 5'd0;
        test_reset();
        test_rtype();
        test_load_link();
        test_cond_write();
        test_reg_zero();
        test_back_to_back();
        test_retire();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file; the consumer of the MEM/WB pipeline register outputs.
- Selects the write-back data and destination register, then commits the result into a 32x32 register file.
- Serves two asynchronous read ports to the ID stage, with write-through bypass.
- Exposes the committed write to the forwarding/hazard logic and counts retired instructions.

Parameters:
- NREGS, 32, number of architectural registers (index width 5).
- DW, 32, data width.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ALUResult_WB  input  32  ALU result from the MEM/WB register.
- ReadDataFromMem_WB  input  32  load data from the MEM/WB register.
- NextInstruct_WB  input  32  link address (return PC) for jal/jalr.
- Instruction_WB  input  32  instruction word; supplies the rt[20:16] and rd[15:11] fields.
- MemtoReg_WB  input  1  1 = write load data, 0 = write ALU result.
- RegWrite_WB  input  1  write enable.
- RegWriteSel_WB  input  1  1 = conditional write (movz-style), gated by Zero_WB.
- Zero_WB  input  1  condition flag for conditional write.
- RegDst_WB  input  2  destination select: 00 rt, 01 rd, 10 $31 link, 11 rd link.
- ReadReg1  input  5  ID-stage read address, port 1.
- ReadReg2  input  5  ID-stage read address, port 2.
- ReadData1  output  32  register file read data, port 1.
- ReadData2  output  32  register file read data, port 2.
- WBWriteEn  output  1  effective write enable this cycle (for forwarding).
- WBWriteReg  output  5  effective destination register.
- WBWriteData  output  32  effective write data.
- RetiredCount  output  32  count of retired non-bubble instructions.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All 32 registers cleared to 0; RetiredCount cleared to 0.
  - All writes suppressed while Reset=0.
  - Combinational outputs follow their equations; reads return 0 for any address.
  - Reset asserted mid-cycle discards that cycle's pending write.
- Destination select:
  - RegDst 00: WBWriteReg = Instruction_WB[20:16].
  - RegDst 01: WBWriteReg = Instruction_WB[15:11].
  - RegDst 10: WBWriteReg = 31.
  - RegDst 11: WBWriteReg = Instruction_WB[15:11].
- Data select:
  - RegDst 1x: WBWriteData = NextInstruct_WB (link), regardless of MemtoReg_WB.
  - Otherwise MemtoReg_WB=1: WBWriteData = ReadDataFromMem_WB.
  - Otherwise: WBWriteData = ALUResult_WB.
- Effective enable:
  - WBWriteEn = RegWrite_WB & (~RegWriteSel_WB | Zero_WB) & (WBWriteReg != 0).
  - All three are purely combinational.
- Commit:
  - On posedge Clk with Reset=1 and WBWriteEn=1: reg[WBWriteReg] <= WBWriteData.
  - Latency: value is architecturally visible from the next cycle.
- Register $0:
  - Never written; always reads 0.
  - WBWriteEn is forced 0 when the destination is 0.
- Reads (combinational):
  - ReadDataN = 0 if ReadRegN == 0.
  - Else WBWriteData if WBWriteEn && ReadRegN == WBWriteReg (write-through bypass, same cycle).
  - Else reg[ReadRegN].
  - Both ports may hit the same address or the write address simultaneously; both return identical values.
- RetiredCount:
  - Increments by 1 on posedge Clk when Reset=1 and Instruction_WB != 32'h0 (NOP/bubble not counted).
  - Increments independently of WBWriteEn.
  - Wraps from 32'hFFFFFFFF to 0 without a flag.
- No stall input: the stage commits every cycle. The upstream pipeline register inserts bubbles by zeroing RegWrite_WB and Instruction_WB.

Test Plan:
- Reset pulse low mid-cycle after writing reg 5 = 32'h1234 -> ReadData1(5) = 0 immediately, and RetiredCount = 0.
- R-type: RegDst=01, rd=8, ALUResult=32'hDEADBEEF, RegWrite=1; same cycle ReadReg1=8 -> ReadData1 = 32'hDEADBEEF via bypass; the following cycle with RegWrite=0 it still reads 32'hDEADBEEF.
- Load vs ALU: MemtoReg=1, RegDst=00, rt=9, mem=32'hA5A5A5A5, ALU=32'h1 -> reg 9 = 32'hA5A5A5A5; jal RegDst=10, NextInstruct=32'h00400010 -> reg 31 = 32'h00400010.
- Conditional write: RegWriteSel=1, Zero=0, rd=10, ALU=32'h77 -> WBWriteEn=0 and reg 10 unchanged; repeat with Zero=1 -> reg 10 = 32'h77.
- Write to $0 with ALU=32'hFFFFFFFF, RegWrite=1 -> WBWriteEn=0, ReadData1(0)=ReadData2(0)=0.
- Retire count: 5 non-zero instructions interleaved with 3 zero words -> RetiredCount = 5; force count to 32'hFFFFFFFF and retire one -> 0.
